mackerel_dtack_ctrl: RTL
========================

// Module: mackerel_dtack_ctrl
// PURPOSE
//   Bus-cycle terminator for the 68000 local bus. Watches AS and the decoder's active-low selects.
//   Terminates each cycle by asserting DTACK after a per-region count of wait states.
//   Asserts BERR on unmapped or hung cycles. Sits beside mackerel_decoder and is clocked by CLK_GEN.
// PARAMETERS
//   ROM_WS   2    wait states (CLK cycles) inserted before DTACK for ROM cycles, 0..15
//   RAM_WS   0    wait states for RAM cycles, 0..15
//   MFP_WS   4    wait states for MFP cycles, 0..15 (unused when MFP_DTACK_EN defined)
//   TIMEOUT  64   CLK cycles from cycle start to BERR if no DTACK issued, 2..255
// PORTS
//   CLK         in   1  CPU clock (CLK_GEN); all logic on rising edge
//   RST         in   1  synchronous reset, active low
//   AS          in   1  CPU address strobe, active low
//   ROMEN       in   1  ROM select from decoder, active low
//   RAMEN       in   1  RAM select (any RAM bank), active low
//   MFPEN       in   1  MFP select, active low
//   MFP_DTACK   in   1  DTACK from MFP, active low (ignored unless MFP_DTACK_EN)
//   DTACK       out  1  data-transfer acknowledge to CPU, active low, registered
//   BERR        out  1  bus error to CPU, active low, registered
//   BERR_CNT    out  8  saturating count of BERR events since reset
// BEHAVIOUR
//   Reset: RST low at a rising edge -> state IDLE, DTACK=1, BERR=1, BERR_CNT=0, counters 0.
//     Reset overrides everything, including a cycle in progress.
//   States: IDLE, WAIT, ACK, FAULT.
//   IDLE: on an edge with AS=0, select region by priority ROM > RAM > MFP.
//     Load ws_cnt with that region's WS and set to_cnt=1. Go to WAIT.
//     No select active -> unmapped: ws_cnt not used, go to WAIT flagged unmapped.
//   WAIT: to_cnt increments every edge, saturating at 255.
//     Mapped, ws_cnt==0 -> next state ACK, DTACK<=0 on that edge.
//     Mapped, ws_cnt!=0 -> decrement ws_cnt.
//     Latency: WS=n -> DTACK low at the (n+1)th rising edge after the edge that sampled AS=0.
//     to_cnt==TIMEOUT before DTACK -> FAULT, BERR<=0, BERR_CNT+=1 (saturate at 255).
//     Unmapped cycles always end this way.
//   ACK: hold DTACK=0 while AS=0. First edge sampling AS=1 -> DTACK<=1, go to IDLE.
//   FAULT: hold BERR=0 while AS=0. First edge sampling AS=1 -> BERR<=1, go to IDLE.
//   Aborted cycle: AS=1 sampled in WAIT -> IDLE, DTACK/BERR stay 1, no count change.
//   Select change mid-cycle: region is latched at cycle start; later select changes are ignored.
//   Timeout vs wait-state expiry on the same edge: DTACK wins; BERR not asserted.
//   DTACK and BERR are never both 0.
//   Back-to-back cycles: a new cycle needs at least one edge in IDLE (AS=1 edge already consumed).
// CONFIGURATION
//   MFP_DTACK_EN defined: MFP cycles ignore MFP_WS.
//     In WAIT, MFP_DTACK sampled 0 -> DTACK<=0, go to ACK; timeout still applies.
//     MFP_DTACK is double-registered before use, so add 2 cycles to the response latency.
//   MFP_DTACK_EN undefined: MFP_DTACK unused; MFP cycles use MFP_WS like other regions.
// TESTING
//   Reset: hold RST=0 for 3 edges mid-WAIT -> DTACK=1, BERR=1, BERR_CNT=0, then first cycle behaves normally.
//   RAM cycle, RAM_WS=0: AS=0, RAMEN=0 sampled at edge k -> DTACK=0 after edge k+1; AS=1 at edge k+4 -> DTACK=1 after k+4.
//   ROM cycle, ROM_WS=2: DTACK low after edge k+3, never earlier; ROMEN and RAMEN both 0 -> ROM timing used.
//   Unmapped: AS=0, all selects 1, TIMEOUT=64 -> BERR=0 after edge k+64, DTACK stays 1, BERR_CNT=1; 300 such cycles -> BERR_CNT=255.
//   Abort: ROM_WS=5, AS returns high at edge k+2 -> no DTACK, no BERR; next cycle starts clean.
//   MFP_DTACK_EN: MFP_DTACK driven 0 at edge k+6 -> DTACK=0 after edge k+8; MFP_DTACK never asserted -> BERR at k+64.

Source files
------------

// File: rtl/mackerel_dtack_ctrl.sv
// mackerel_dtack_ctrl: 68000 local-bus cycle terminator (DTACK / BERR).
// Build option: define MFP_DTACK_EN to let the MFP terminate its own cycles.
//
// Ports:
//   CLK        CPU clock; all state changes on the rising edge
//   RST        synchronous reset, active low
//   AS         CPU address strobe, active low
//   ROMEN      ROM select from the decoder, active low
//   RAMEN      RAM select (any bank), active low
//   MFPEN      MFP select, active low
//   MFP_DTACK  DTACK from the MFP, active low (used only with MFP_DTACK_EN)
//   DTACK      registered data-transfer acknowledge, active low
//   BERR       registered bus error, active low
//   BERR_CNT   saturating count of bus errors since reset
//
// Parameters:
//   ROM_WS, RAM_WS, MFP_WS  wait states per region (0..15)
//   TIMEOUT                 cycles from cycle start to BERR (2..255)

module mackerel_dtack_ctrl #(
  parameter int ROM_WS  = 2,
  parameter int RAM_WS  = 0,
  parameter int MFP_WS  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       AS,
  input  logic       ROMEN,
  input  logic       RAMEN,
  input  logic       MFPEN,
  input  logic       MFP_DTACK,
  output logic       DTACK,
  output logic       BERR,
  output logic [7:0] BERR_CNT
);

  localparam logic [3:0] ROM_WS_C  = 4'(ROM_WS);
  localparam logic [3:0] RAM_WS_C  = 4'(RAM_WS);
  localparam logic [3:0] MFP_WS_C  = 4'(MFP_WS);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    R_NONE,
    R_ROM,
    R_RAM,
    R_MFP
  } region_t;

  state_t     state_q, state_d;
  region_t    region_q, region_d;
  logic [3:0] ws_cnt_q, ws_cnt_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       dtack_q, dtack_d;
  logic       berr_q, berr_d;
  logic [7:0] berr_cnt_q, berr_cnt_d;

  // High when the latched region is ready to be acknowledged this edge.
  logic       ack_now;

`ifdef MFP_DTACK_EN
  // MFP_DTACK is asynchronous to CLK; two flops before it is used.
  logic mfp_s1_q, mfp_s1_d;
  logic mfp_s2_q, mfp_s2_d;

  always_comb begin
    mfp_s1_d = MFP_DTACK;
    mfp_s2_d = mfp_s1_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      mfp_s1_q <= 1'b1;
      mfp_s2_q <= 1'b1;
    end else begin
      mfp_s1_q <= mfp_s1_d;
      mfp_s2_q <= mfp_s2_d;
    end
  end

  always_comb begin
    ack_now = 1'b0;
    if (region_q == R_MFP) begin
      ack_now = !mfp_s2_q;
    end else if (region_q != R_NONE) begin
      ack_now = (ws_cnt_q == 4'd0);
    end
  end
`else
  logic unused_mfp_dtack;
  assign unused_mfp_dtack = MFP_DTACK;

  always_comb begin
    ack_now = 1'b0;
    if (region_q != R_NONE) begin
      ack_now = (ws_cnt_q == 4'd0);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    region_d   = region_q;
    ws_cnt_d   = ws_cnt_q;
    to_cnt_d   = to_cnt_q;
    dtack_d    = dtack_q;
    berr_d     = berr_q;
    berr_cnt_d = berr_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        dtack_d = 1'b1;
        berr_d  = 1'b1;
        if (!AS) begin
          state_d  = S_WAIT;
          to_cnt_d = 8'd1;
          // Region is fixed here; later select changes are ignored.
          if (!ROMEN) begin
            region_d = R_ROM;
            ws_cnt_d = ROM_WS_C;
          end else if (!RAMEN) begin
            region_d = R_RAM;
            ws_cnt_d = RAM_WS_C;
          end else if (!MFPEN) begin
            region_d = R_MFP;
            ws_cnt_d = MFP_WS_C;
          end else begin
            region_d = R_NONE;
            ws_cnt_d = 4'd0;
          end
        end
      end

      S_WAIT: begin
        if (to_cnt_q != 8'hFF) begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
        // Order matters: abort, then DTACK, then timeout.
        if (AS) begin
          state_d = S_IDLE;
        end else if (ack_now) begin
          state_d = S_ACK;
          dtack_d = 1'b0;
        end else if (to_cnt_q == TIMEOUT_C) begin
          state_d = S_FAULT;
          berr_d  = 1'b0;
          if (berr_cnt_q != 8'hFF) begin
            berr_cnt_d = berr_cnt_q + 8'd1;
          end
        end else if (ws_cnt_q != 4'd0) begin
          ws_cnt_d = ws_cnt_q - 4'd1;
        end
      end

      S_ACK: begin
        if (AS) begin
          state_d = S_IDLE;
          dtack_d = 1'b1;
        end
      end

      S_FAULT: begin
        if (AS) begin
          state_d = S_IDLE;
          berr_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        dtack_d = 1'b1;
        berr_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      region_q   <= R_NONE;
      ws_cnt_q   <= 4'd0;
      to_cnt_q   <= 8'd0;
      dtack_q    <= 1'b1;
      berr_q     <= 1'b1;
      berr_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      ws_cnt_q   <= ws_cnt_d;
      to_cnt_q   <= to_cnt_d;
      dtack_q    <= dtack_d;
      berr_q     <= berr_d;
      berr_cnt_q <= berr_cnt_d;
    end
  end

  assign DTACK    = dtack_q;
  assign BERR     = berr_q;
  assign BERR_CNT = berr_cnt_q;

endmodule
